// File: rtl/wb_stage_nl_pkg.sv
// Shared types for the N-lane write-back stage: memory-stage lane layout, trace entry, exception codes.
// The lane struct is packed MSB-first, so lane i sits at ms_to_ws_bus[i*WS_LANE_WD +: WS_LANE_WD].
package wb_stage_nl_pkg;

    typedef struct packed {
        logic        lv;
        logic        rdcntid;
        logic        has_int;
        logic        adef;
        logic        ine;
        logic        sys;
        logic        brk;
        logic        ale;
        logic [31:0] badv;
        logic        ertn;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ws_lane_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_ent_t;

    localparam int WS_LANE_WD  = $bits(ws_lane_t);
    localparam int WS_RF_WD    = 38;
    localparam int WS_TRACE_WD = $bits(trace_ent_t);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    // Interrupts are only sampled on the oldest lane, hence int_ok.
    function automatic logic lane_has_ex(ws_lane_t l, logic int_ok);
        return l.lv && ((int_ok && l.has_int) || l.adef || l.ine || l.sys || l.brk || l.ale);
    endfunction

    // Returns {esubcode, ecode} for the highest-priority exception of a lane.
    function automatic logic [14:0] lane_excode(ws_lane_t l, logic int_ok);
        if (int_ok && l.has_int) return {ESUBCODE_NONE, ECODE_INT};
        else if (l.adef)         return {ESUBCODE_ADEF, ECODE_ADEF};
        else if (l.ine)          return {ESUBCODE_NONE, ECODE_INE};
        else if (l.sys)          return {ESUBCODE_NONE, ECODE_SYS};
        else if (l.brk)          return {ESUBCODE_NONE, ECODE_BRK};
        else                     return {ESUBCODE_NONE, ECODE_ALE};
    endfunction

endpackage

// File: rtl/wb_stage_nl_trace_fifo.sv
// Trace FIFO: up to LANES compacted pushes per cycle in lane order, one pop per cycle whenever non-empty.
// DEPTH must be a power of two and at least 2; free_o reports empty slots before this cycle's pop.
module wb_trace_fifo
    import wb_stage_nl_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  LANES = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [LANES-1:0]             push_vld_i,
    input  logic [LANES*WS_TRACE_WD-1:0] push_data_i,
    output logic                         head_vld_o,
    output logic [WS_TRACE_WD-1:0]       head_o,
    output logic [CW-1:0]                free_o
);

    logic [WS_TRACE_WD-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          push_cnt;
    logic [AW-1:0]          off [LANES];

    assign head_vld_o = (cnt_q != '0);
    assign head_o     = head_vld_o ? mem_q[rptr_q] : '0;
    assign free_o     = CW'(DEPTH) - cnt_q;

    // off[i] is the slot of lane i among the lanes pushing this cycle.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            off[i]   = push_cnt[AW-1:0];
            push_cnt = push_cnt + CW'(push_vld_i[i]);
        end
        cnt_d = cnt_q + push_cnt - CW'(head_vld_o);
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_vld_i[i]) mem_q[wptr_q + off[i]] <= push_data_i[i*WS_TRACE_WD +: WS_TRACE_WD];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + push_cnt[AW-1:0];
            if (head_vld_o) rptr_q <= rptr_q + AW'(1);
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_stage_nl.sv
// N-lane LoongArch write-back stage: lane-ordered exception/ERTN arbitration, RF write ports, CSR/flush.
// Define WS_TRACE_EN to serialise committed writes through wb_trace_fifo onto the debug port.
module wb_stage_nl
    import wb_stage_nl_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic                        ws_allowin,
    input  logic                        ms_to_ws_valid,
    input  logic [LANES*WS_LANE_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                 ws_tid_rvalue,
    output logic [LANES*WS_RF_WD-1:0]   ws_to_rf_bus,
    output logic                        ws_ex,
    output logic                        ws_csr_eret_flush,
    output logic                        ws_block,
    output logic [5:0]                  ws_csr_ecode,
    output logic [8:0]                  ws_csr_esubcode,
    output logic [31:0]                 ws_vaddr,
    output logic [31:0]                 ws_ex_pc,
    output logic                        ws_csr_we,
    output logic [13:0]                 ws_csr_num,
    output logic [31:0]                 ws_csr_wdata,
    output logic [31:0]                 ws_csr_wmask,
    output logic [31:0]                 ws_retire_cnt,
    output logic [31:0]                 debug_wb_pc,
    output logic [3:0]                  debug_wb_rf_wen,
    output logic [4:0]                  debug_wb_rf_wnum,
    output logic [31:0]                 debug_wb_rf_wdata
);

    if (TRACE_DEPTH < LANES || TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_stage_nl: TRACE_DEPTH must be a power of two, >= 2 and >= LANES");
    end

    logic                        ws_valid_q;
    logic [LANES*WS_LANE_WD-1:0] bus_q;
    logic [31:0]                 retire_q;

    ws_lane_t         lane [LANES];
    logic [LANES-1:0] commit, rf_we;
    logic [31:0]      rf_wdata [LANES];
    logic [3:0]       n_commit;
    logic             ex_hit, ertn_hit, stop;
    logic [14:0]      win_code;
    logic [31:0]      win_badv, win_pc;
    logic             ready_go, fire;

    always_comb begin
        for (int i = 0; i < LANES; i++) lane[i] = ws_lane_t'(bus_q[i*WS_LANE_WD +: WS_LANE_WD]);
    end

    // Walk lanes oldest-first; the first exception or ERTN closes the bundle for younger lanes.
    always_comb begin
        commit   = '0;
        n_commit = '0;
        ex_hit   = 1'b0;
        ertn_hit = 1'b0;
        stop     = 1'b0;
        win_code = '0;
        win_badv = '0;
        win_pc   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ws_valid_q && !stop && lane[i].lv) begin
                if (lane_has_ex(lane[i], i == 0)) begin
                    ex_hit   = 1'b1;
                    stop     = 1'b1;
                    win_code = lane_excode(lane[i], i == 0);
                    win_badv = lane[i].badv;
                    win_pc   = lane[i].pc;
                end else begin
                    commit[i] = 1'b1;
                    n_commit  = n_commit + 4'd1;
                    if (lane[i].ertn) begin
                        ertn_hit = 1'b1;
                        stop     = 1'b1;
                    end
                end
            end
        end
    end

    assign fire              = ws_valid_q && ready_go;
    assign ws_allowin        = !ws_valid_q || ready_go;
    assign ws_ex             = fire && ex_hit;
    assign ws_csr_eret_flush = fire && ertn_hit;
    assign ws_block          = ws_ex || ws_csr_eret_flush;
    assign ws_csr_ecode      = ws_ex ? win_code[5:0]  : '0;
    assign ws_csr_esubcode   = ws_ex ? win_code[14:6] : '0;
    assign ws_vaddr          = ws_ex ? win_badv : '0;
    assign ws_ex_pc          = ws_ex ? win_pc   : '0;
    assign ws_csr_we         = fire && lane[0].lv && lane[0].csr_we && !lane_has_ex(lane[0], 1'b1);
    assign ws_csr_num        = lane[0].csr_num;
    assign ws_csr_wdata      = lane[0].csr_wdata;
    assign ws_csr_wmask      = lane[0].csr_wmask;
    assign ws_retire_cnt     = retire_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rf_we[i]    = fire && commit[i] && lane[i].gr_we;
            rf_wdata[i] = lane[i].rdcntid ? ws_tid_rvalue : lane[i].result;
            ws_to_rf_bus[i*WS_RF_WD +: WS_RF_WD] = {rf_we[i], lane[i].dest, rf_wdata[i]};
        end
    end

`ifdef WS_TRACE_EN
    localparam int TAW = $clog2(TRACE_DEPTH);

    logic [LANES*WS_TRACE_WD-1:0] tr_push;
    logic                         tr_head_vld;
    logic [WS_TRACE_WD-1:0]       tr_head;
    logic [TAW:0]                 tr_free;
    trace_ent_t                   tr_ent;

    always_comb begin
        for (int i = 0; i < LANES; i++) tr_push[i*WS_TRACE_WD +: WS_TRACE_WD] = {lane[i].pc, lane[i].dest, rf_wdata[i]};
    end

    wb_trace_fifo #(.DEPTH(TRACE_DEPTH), .LANES(LANES)) u_trace (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .push_vld_i  (rf_we),
        .push_data_i (tr_push),
        .head_vld_o  (tr_head_vld),
        .head_o      (tr_head),
        .free_o      (tr_free)
    );

    // The head leaves this cycle, so its slot already counts as free.
    assign ready_go          = (32'(tr_free) + 32'(tr_head_vld)) >= 32'(n_commit);
    assign tr_ent            = trace_ent_t'(tr_head);
    assign debug_wb_pc       = tr_ent.pc;
    assign debug_wb_rf_wen   = {4{tr_head_vld}};
    assign debug_wb_rf_wnum  = tr_ent.wnum;
    assign debug_wb_rf_wdata = tr_ent.wdata;
`else
    assign ready_go          = 1'b1;
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

    // A flush kills whatever bundle is accepted alongside it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
            retire_q   <= '0;
        end else begin
            if (ws_block)        ws_valid_q <= 1'b0;
            else if (ws_allowin) ws_valid_q <= ms_to_ws_valid;
            if (ms_to_ws_valid && ws_allowin) bus_q <= ms_to_ws_bus;
            if (fire) retire_q <= retire_q + 32'(n_commit);
        end
    end

endmodule

// File: tb/tb_wb_stage_nl.sv
// Directed bench for wb_stage_nl (LANES=2, TRACE_DEPTH=2); trace-port checks depend on WS_TRACE_EN.
module tb_wb_stage_nl;
    import wb_stage_nl_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 2;

    logic                        clk = 1'b0;
    logic                        resetn = 1'b0;
    logic                        ws_allowin;
    logic                        ms_valid;
    logic [LANES*WS_LANE_WD-1:0] ms_bus;
    logic [31:0]                 tid;
    logic [LANES*WS_RF_WD-1:0]   rf_bus;
    logic                        ws_ex, eret, blk, csr_we;
    logic [5:0]                  ecode;
    logic [8:0]                  esub;
    logic [31:0]                 vaddr, ex_pc, csr_wdata, csr_wmask, retire;
    logic [13:0]                 csr_num;
    logic [31:0]                 dbg_pc, dbg_wdata;
    logic [3:0]                  dbg_wen;
    logic [4:0]                  dbg_wnum;

    always #5 clk = ~clk;

    wb_stage_nl #(.LANES(LANES), .TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_valid), .ms_to_ws_bus(ms_bus), .ws_tid_rvalue(tid),
        .ws_to_rf_bus(rf_bus), .ws_ex(ws_ex), .ws_csr_eret_flush(eret), .ws_block(blk),
        .ws_csr_ecode(ecode), .ws_csr_esubcode(esub), .ws_vaddr(vaddr), .ws_ex_pc(ex_pc),
        .ws_csr_we(csr_we), .ws_csr_num(csr_num), .ws_csr_wdata(csr_wdata), .ws_csr_wmask(csr_wmask),
        .ws_retire_cnt(retire), .debug_wb_pc(dbg_pc), .debug_wb_rf_wen(dbg_wen),
        .debug_wb_rf_wnum(dbg_wnum), .debug_wb_rf_wdata(dbg_wdata)
    );

    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret = '0;
    logic [4:0]  tq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rf_we(int i);
        return rf_bus[i*WS_RF_WD + 37];
    endfunction
    function automatic logic [4:0] rf_addr(int i);
        return rf_bus[i*WS_RF_WD + 32 +: 5];
    endfunction
    function automatic logic [31:0] rf_data(int i);
        return rf_bus[i*WS_RF_WD +: 32];
    endfunction

    function automatic ws_lane_t wr(logic [31:0] pc, logic [4:0] d, logic [31:0] r);
        ws_lane_t l = '0;
        l.lv = 1'b1; l.gr_we = 1'b1; l.dest = d; l.result = r; l.pc = pc;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle while the stage is idle; returns in its commit cycle.
    task automatic load(input ws_lane_t l0, input ws_lane_t l1);
        ms_valid = 1'b1;
        ms_bus   = {l1, l0};
        tick();
        ms_valid = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn && dbg_wen == 4'hf) tq.push_back(dbg_wnum);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ws_lane_t a, b;
        int nb, stalls, guard;
        logic acc;
        ms_valid = 1'b0;
        ms_bus   = '0;
        tid      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_allowin", ws_allowin, 1);
        chk("rst_retire", retire, 0);
        chk("rst_wen", dbg_wen, 0);
        chk("rst_rf", |rf_bus, 0);
        chk("rst_block", blk, 0);
        resetn = 1'b1;
        tick();

        // two writes in one bundle
        load(wr(32'h1000, 5'd3, 32'h11), wr(32'h1004, 5'd4, 32'h22));
        chk("t1_we0", rf_we(0), 1);
        chk("t1_we1", rf_we(1), 1);
        chk("t1_addr0", rf_addr(0), 3);
        chk("t1_addr1", rf_addr(1), 4);
        chk("t1_data0", rf_data(0), 32'h11);
        chk("t1_data1", rf_data(1), 32'h22);
        chk("t1_ex", ws_ex, 0);
        exp_ret += 2;
        tick();
        chk("t1_retire", retire, exp_ret);
`ifdef WS_TRACE_EN
        chk("t1_tr0_wen", dbg_wen, 4'hf);
        chk("t1_tr0_wnum", dbg_wnum, 3);
        chk("t1_tr0_pc", dbg_pc, 32'h1000);
        chk("t1_tr0_wdata", dbg_wdata, 32'h11);
        tick();
        chk("t1_tr1_wnum", dbg_wnum, 4);
        chk("t1_tr1_wdata", dbg_wdata, 32'h22);
        tick();
        chk("t1_tr_empty", dbg_wen, 0);
`else
        chk("t1_wen_off", dbg_wen, 0);
        chk("t1_pc_off", dbg_pc, 0);
        chk("t1_wdata_off", {dbg_wnum, dbg_wdata}, 0);
        tick();
        tick();
`endif
        tick();
        tq.delete();

        // lane1 ALE, lane0 commits
        b = wr(32'h2004, 5'd6, 32'h66); b.ale = 1'b1; b.badv = 32'h1003;
        load(wr(32'h2000, 5'd5, 32'h55), b);
        chk("t2_we0", rf_we(0), 1);
        chk("t2_we1", rf_we(1), 0);
        chk("t2_ex", ws_ex, 1);
        chk("t2_ecode", ecode, 6'h09);
        chk("t2_vaddr", vaddr, 32'h1003);
        chk("t2_expc", ex_pc, 32'h2004);
        chk("t2_block", blk, 1);
        exp_ret += 1;
        tick();
        chk("t2_retire", retire, exp_ret);
        tick();

        // lane0 ADEF+INE; bundle offered during the flush is discarded
        a = wr(32'h3000, 5'd7, 32'h77); a.adef = 1'b1; a.ine = 1'b1;
        load(a, wr(32'h3004, 5'd8, 32'h88));
        ms_valid = 1'b1;
        ms_bus   = {ws_lane_t'('0), wr(32'h3100, 5'd9, 32'h99)};
        #1;
        chk("t3_ex", ws_ex, 1);
        chk("t3_ecode", ecode, 6'h08);
        chk("t3_esub", esub, 0);
        chk("t3_expc", ex_pc, 32'h3000);
        chk("t3_we", {rf_we(1), rf_we(0)}, 0);
        chk("t3_allowin", ws_allowin, 1);
        tick();
        ms_valid = 1'b0;
        #1;
        chk("t3_bubble_we", rf_we(0), 0);
        chk("t3_bubble_ex", ws_ex, 0);
        chk("t3_retire", retire, exp_ret);
        tick();
        chk("t3_retire2", retire, exp_ret);

        // priority and CSR suppression
        a = '0; a.lv = 1'b1; a.sys = 1'b1; a.csr_we = 1'b1; a.csr_num = 14'h6;
        load(a, '0);
        chk("t3b_ecode_sys", ecode, 6'h0B);
        chk("t3b_csr_we", csr_we, 0);
        tick();
        a = '0; a.lv = 1'b1; a.has_int = 1'b1; a.adef = 1'b1; a.brk = 1'b1;
        load(a, '0);
        chk("t3c_ecode_int", ecode, 6'h00);
        chk("t3c_ex", ws_ex, 1);
        tick();
        a = '0; a.lv = 1'b1; a.brk = 1'b1; a.ale = 1'b1;
        load(a, '0);
        chk("t3d_ecode_brk", ecode, 6'h0C);
        tick();

        // ERTN in lane0 suppresses lane1
        a = '0; a.lv = 1'b1; a.ertn = 1'b1; a.pc = 32'h4000;
        load(a, wr(32'h4004, 5'd10, 32'haa));
        chk("t4_eret", eret, 1);
        chk("t4_ex", ws_ex, 0);
        chk("t4_block", blk, 1);
        chk("t4_we1", rf_we(1), 0);
        exp_ret += 1;
        tick();
        chk("t4_retire", retire, exp_ret);
        tick();

        // lane0 CSR write + RDCNTID, lane1 empty
        tid = 32'habcd0001;
        a = wr(32'h5000, 5'd1, 32'h5); a.rdcntid = 1'b1;
        a.csr_we = 1'b1; a.csr_num = 14'h6; a.csr_wdata = 32'hdead; a.csr_wmask = 32'hffff;
        load(a, '0);
        chk("t5_csr_we", csr_we, 1);
        chk("t5_csr_num", csr_num, 14'h6);
        chk("t5_csr_wdata", csr_wdata, 32'hdead);
        chk("t5_csr_wmask", csr_wmask, 32'hffff);
        chk("t5_tid", rf_data(0), 32'habcd0001);
        chk("t5_we1", rf_we(1), 0);
        exp_ret += 1;
        repeat (4) tick();
        chk("t5_retire", retire, exp_ret);
`ifdef WS_TRACE_EN
        chk("t2_5_trace_n", tq.size(), 2);
        if (tq.size() == 2) begin
            chk("t2_5_trace0", tq[0], 5);
            chk("t2_5_trace1", tq[1], 1);
        end
`else
        chk("t2_5_trace_n", tq.size(), 0);
`endif

        // back-to-back two-write bundles
        tq.delete();
        nb = 0; stalls = 0; guard = 0;
        ms_valid = 1'b1;
        ms_bus   = {wr(32'h6004, 5'd11, 32'h611), wr(32'h6000, 5'd10, 32'h610)};
        while (nb < 3 && guard < 30) begin
            acc = ws_allowin;
            tick();
            guard++;
            if (acc) begin
                nb++;
                if (nb < 3) ms_bus = {wr(32'h6004, 5'(11 + 2*nb), 32'h611), wr(32'h6000, 5'(10 + 2*nb), 32'h610)};
                else ms_valid = 1'b0;
            end else stalls++;
        end
        ms_valid = 1'b0;
        chk("t6_accepted", nb, 3);
        repeat (10) tick();
        exp_ret += 6;
        chk("t6_retire", retire, exp_ret);
`ifdef WS_TRACE_EN
        chk("t6_stalled", stalls > 0, 1);
        chk("t6_trace_n", tq.size(), 6);
        for (int i = 0; i < 6 && i < tq.size(); i++) chk("t6_trace_order", tq[i], 10 + i);
`else
        chk("t6_stalls", stalls, 0);
        chk("t6_trace_n", tq.size(), 0);
`endif

        // async reset with two trace entries queued
        load(wr(32'h7000, 5'd20, 32'h70), wr(32'h7004, 5'd21, 32'h71));
        tick();
`ifdef WS_TRACE_EN
        chk("t7_pre_wen", dbg_wen, 4'hf);
`endif
        chk("t7_pre_retire", retire, exp_ret + 2);
        resetn = 1'b0;
        #1;
        chk("t7_wen", dbg_wen, 0);
        chk("t7_retire", retire, 0);
        chk("t7_rf", |rf_bus, 0);
        chk("t7_allowin", ws_allowin, 1);
        #1;
        resetn = 1'b1;
        tick();
        chk("t7_post_wen", dbg_wen, 0);
        chk("t7_post_retire", retire, 0);
        tick();
        chk("t7_post_wen2", dbg_wen, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
